// File: rtl/uart_pkg.sv
// Shared UART timebase defaults and divisor helpers used by the baud generator and the TX/RX engines.
package uart_pkg;

    localparam int unsigned DEF_INT_W   = 16;
    localparam int unsigned DEF_FRAC_W  = 4;
    localparam int unsigned DEF_OVS     = 16;
    localparam int unsigned DEF_RST_DIV = 325;

    // A zero divisor would never reach a boundary, so it is read as one.
    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        return (div == 32'd0) ? 32'd1 : div;
    endfunction

endpackage

// File: rtl/uart_baud_frac_acc.sv
// Fractional phase accumulator for uart_baud_gen_frac: holds acc, produces the period-stretch carry,
// and clears on Resync. Only instantiated when UART_BAUD_FRAC_EN is defined.
module uart_baud_frac_acc #(
    parameter int unsigned FRAC_W = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Resync,
    input  logic              Advance,
    input  logic [FRAC_W-1:0] Frac,
    output logic              Carry
);

    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [FRAC_W:0]   sum;

    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, Frac};
        Carry = sum[FRAC_W];
        acc_d = acc_q;
        if (Resync) begin
            acc_d = '0;
        end else if (Advance) begin
            acc_d = sum[FRAC_W-1:0];
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Fractional-N oversample tick generator with bit/mid-bit strobes and glitch-free divisor updates.
// Define UART_BAUD_FRAC_EN to include the fractional accumulator; otherwise the period is integer.
module uart_baud_gen_frac
    import uart_pkg::*;
#(
    parameter int unsigned INT_W   = DEF_INT_W,
    parameter int unsigned FRAC_W  = DEF_FRAC_W,
    parameter int unsigned OVS     = DEF_OVS,
    parameter int unsigned RST_DIV = DEF_RST_DIV
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    En,
    input  logic                    Resync,
    input  logic [INT_W-1:0]        Div_int,
    input  logic [FRAC_W-1:0]       Div_frac,
    input  logic                    Div_load,
    output logic                    Div_ack,
    output logic                    Tick,
    output logic                    Bit_tick,
    output logic                    Mid_tick,
    output logic [$clog2(OVS)-1:0]  Phase
);

    localparam int unsigned     CNT_W   = INT_W + 1;
    localparam int unsigned     PH_W    = $clog2(OVS);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS - 1);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVS / 2 - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [INT_W-1:0]  act_int_q, act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [INT_W-1:0]  pend_int_q, pend_int_d;
    logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
    logic              pend_vld_q, pend_vld_d;
    logic              tick_q, tick_d;
    logic              bit_tick_q, bit_tick_d;
    logic              mid_tick_q, mid_tick_d;
    logic              div_ack_q, div_ack_d;

    logic              carry;
    logic              advance;
    logic              apply;
    logic [CNT_W-1:0]  period;

`ifdef UART_BAUD_FRAC_EN
    uart_baud_frac_acc #(
        .FRAC_W (FRAC_W)
    ) u_frac_acc (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .Resync  (Resync),
        .Advance (advance),
        .Frac    (act_frac_q),
        .Carry   (carry)
    );
`else
    logic unused_frac;
    assign carry       = 1'b0;
    assign unused_frac = ^{act_frac_q, advance};
`endif

    assign period = CNT_W'(clamp_div(32'(act_int_q))) + CNT_W'(carry);

    // Period counter and phase. The >= compare also ends a period cleanly when a divisor
    // applied while disabled is already shorter than the count reached.
    always_comb begin
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        tick_d     = 1'b0;
        bit_tick_d = 1'b0;
        mid_tick_d = 1'b0;
        advance    = 1'b0;
        apply      = 1'b0;
        if (Resync) begin
            cnt_d   = CNT_W'(1);
            phase_d = '0;
            apply   = pend_vld_q;
        end else if (!En) begin
            apply = pend_vld_q;
        end else if (cnt_q >= period) begin
            cnt_d      = CNT_W'(1);
            phase_d    = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
            tick_d     = 1'b1;
            bit_tick_d = (phase_q == PH_LAST);
            mid_tick_d = (phase_q == PH_MID);
            advance    = 1'b1;
            apply      = pend_vld_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // A load on the same edge as an application wins the pending slot.
    always_comb begin
        act_int_d   = act_int_q;
        act_frac_d  = act_frac_q;
        pend_int_d  = pend_int_q;
        pend_frac_d = pend_frac_q;
        pend_vld_d  = pend_vld_q;
        div_ack_d   = apply;
        if (apply) begin
            act_int_d  = pend_int_q;
            act_frac_d = pend_frac_q;
            pend_vld_d = 1'b0;
        end
        if (Div_load) begin
            pend_int_d  = Div_int;
            pend_frac_d = Div_frac;
            pend_vld_d  = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q       <= CNT_W'(1);
            phase_q     <= '0;
            act_int_q   <= INT_W'(RST_DIV);
            act_frac_q  <= '0;
            pend_int_q  <= '0;
            pend_frac_q <= '0;
            pend_vld_q  <= 1'b0;
            tick_q      <= 1'b0;
            bit_tick_q  <= 1'b0;
            mid_tick_q  <= 1'b0;
            div_ack_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            act_int_q   <= act_int_d;
            act_frac_q  <= act_frac_d;
            pend_int_q  <= pend_int_d;
            pend_frac_q <= pend_frac_d;
            pend_vld_q  <= pend_vld_d;
            tick_q      <= tick_d;
            bit_tick_q  <= bit_tick_d;
            mid_tick_q  <= mid_tick_d;
            div_ack_q   <= div_ack_d;
        end
    end

    assign Tick     = tick_q;
    assign Bit_tick = bit_tick_q;
    assign Mid_tick = mid_tick_q;
    assign Div_ack  = div_ack_q;
    assign Phase    = phase_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Self-checking bench for uart_baud_gen_frac: directed sequences, a span table and random stimulus
// checked every cycle against an arithmetic reference model.
module tb_uart_baud_gen_frac;
    import uart_pkg::*;

    localparam int unsigned INT_W   = DEF_INT_W;
    localparam int unsigned FRAC_W  = DEF_FRAC_W;
    localparam int unsigned OVS     = DEF_OVS;
    localparam int unsigned RST_DIV = DEF_RST_DIV;
    localparam int unsigned PH_W    = $clog2(OVS);

    logic              Clk = 1'b0;
    logic              Rst_n;
    logic              En;
    logic              Resync;
    logic [INT_W-1:0]  Div_int;
    logic [FRAC_W-1:0] Div_frac;
    logic              Div_load;
    logic              Div_ack;
    logic              Tick;
    logic              Bit_tick;
    logic              Mid_tick;
    logic [PH_W-1:0]   Phase;

    uart_baud_gen_frac #(
        .INT_W   (INT_W),
        .FRAC_W  (FRAC_W),
        .OVS     (OVS),
        .RST_DIV (RST_DIV)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .En       (En),
        .Resync   (Resync),
        .Div_int  (Div_int),
        .Div_frac (Div_frac),
        .Div_load (Div_load),
        .Div_ack  (Div_ack),
        .Tick     (Tick),
        .Bit_tick (Bit_tick),
        .Mid_tick (Mid_tick),
        .Phase    (Phase)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // Reference model: elapsed edges in the current period, tick count since restart, and the
    // fractional remainder as a plain integer.
    int m_e, m_acc, m_ntick, m_ai, m_af, m_pi, m_pf, m_pv;
    bit e_tick, e_bit, e_mid, e_ack;

    function automatic void model_reset();
        m_e = 0; m_acc = 0; m_ntick = 0;
        m_ai = int'(RST_DIV); m_af = 0; m_pi = 0; m_pf = 0; m_pv = 0;
        e_tick = 0; e_bit = 0; e_mid = 0; e_ack = 0;
    endfunction

    function automatic int m_period();
        int p;
        p = (m_ai == 0) ? 1 : m_ai;
`ifdef UART_BAUD_FRAC_EN
        if (m_acc + m_af >= (1 << FRAC_W)) p = p + 1;
`endif
        return p;
    endfunction

    function automatic void model_edge();
        int pre;
        bit apply;
        apply = 0; e_tick = 0; e_bit = 0; e_mid = 0;
        if (Resync) begin
            m_e = 0; m_acc = 0; m_ntick = 0;
            apply = (m_pv != 0);
        end else if (!En) begin
            apply = (m_pv != 0);
        end else if (m_e + 1 >= m_period()) begin
            pre     = m_ntick % int'(OVS);
            e_tick  = 1;
            e_bit   = (pre == int'(OVS) - 1);
            e_mid   = (pre == int'(OVS) / 2 - 1);
            m_ntick = m_ntick + 1;
            m_acc   = (m_acc + m_af) % (1 << FRAC_W);
            m_e     = 0;
            apply   = (m_pv != 0);
        end else begin
            m_e = m_e + 1;
        end
        e_ack = apply;
        if (apply) begin
            m_ai = m_pi; m_af = m_pf; m_pv = 0;
        end
        if (Div_load) begin
            m_pi = int'(Div_int); m_pf = int'(Div_frac); m_pv = 1;
        end
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [PH_W+3:0] got, exp;
        got = {Tick, Bit_tick, Mid_tick, Div_ack, Phase};
        exp = {e_tick, e_bit, e_mid, e_ack, PH_W'(m_ntick % int'(OVS))};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL cycle {tick,bit,mid,ack,phase} got=%b exp=%b t=%0t", got, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge Clk);
        if (Rst_n) model_edge();
        else model_reset();
        #1;
        check_outputs();
    endtask

    task automatic wait_tick(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            cycle();
            if (Tick) begin
                n = i;
                return;
            end
        end
    endtask

    typedef struct {
        int di;
        int df;
        int nticks;
        int span_frac;
        int span_int;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench did not complete");
    end

    initial begin
        int n, acks, ticks, span, tcount, found;

        vecs[0] = '{3, 8, 16, 56, 48};
        vecs[1] = '{1, 0, 10, 10, 10};
        vecs[2] = '{0, 0, 5, 5, 5};
        vecs[3] = '{5, 4, 8, 42, 40};
        vecs[4] = '{2, 15, 4, 11, 8};
        vecs[5] = '{7, 1, 16, 113, 112};

        Rst_n = 1'b0; En = 1'b0; Resync = 1'b0; Div_load = 1'b0;
        Div_int = '0; Div_frac = '0;
        model_reset();
        #12;
        chk("reset_outputs", int'({Tick, Bit_tick, Mid_tick, Div_ack, Phase}), 0);
        check_outputs();
        Rst_n = 1'b1;
        En    = 1'b1;

        // Reset divisor: 325-cycle period, strobes on ticks 8 and 16.
        wait_tick(400, n);
        chk("first_tick", n, 325);
        for (int k = 2; k <= 16; k++) begin
            wait_tick(400, n);
            chk($sformatf("rst_period[%0d]", k), n, 325);
            if (k == 8) chk("mid_on_tick8", int'(Mid_tick), 1);
            if (k == 16) chk("bit_on_tick16", int'(Bit_tick), 1);
        end

        // Load mid-period: current period finishes at 325, then 100.
        repeat (100) cycle();
        Div_int = INT_W'(100); Div_frac = '0; Div_load = 1'b1;
        cycle();
        Div_load = 1'b0;
        wait_tick(400, n);
        chk("load_mid_current", n, 224);
        chk("load_mid_ack", int'(Div_ack), 1);
        cycle();
        chk("ack_one_cycle", int'(Div_ack), 0);
        wait_tick(200, n);
        chk("load_mid_next", n, 99);

        // Load on the boundary edge itself: applied one boundary later.
        repeat (99) cycle();
        Div_int = INT_W'(50); Div_load = 1'b1;
        cycle();
        Div_load = 1'b0;
        chk("coinc_tick", int'(Tick), 1);
        chk("coinc_no_ack", int'(Div_ack), 0);
        wait_tick(200, n);
        chk("coinc_old_period", n, 100);
        chk("coinc_ack", int'(Div_ack), 1);
        wait_tick(200, n);
        chk("coinc_new_period", n, 50);

        // Back-to-back loads: only the second is applied, with one ack.
        repeat (10) cycle();
        Div_int = INT_W'(10); Div_load = 1'b1;
        cycle();
        Div_int = INT_W'(20);
        cycle();
        Div_load = 1'b0;
        acks = 0; n = -1;
        for (int i = 1; i <= 200; i++) begin
            cycle();
            acks += int'(Div_ack);
            if (Tick) begin
                n = i;
                break;
            end
        end
        chk("b2b_period", n, 38);
        chk("b2b_acks", acks, 1);
        wait_tick(100, n);
        chk("b2b_applied", n, 20);

        // En low for 50 cycles mid-period stretches the period by exactly 50.
        repeat (5) cycle();
        En = 1'b0; ticks = 0;
        repeat (50) begin
            cycle();
            ticks += int'(Tick | Bit_tick | Mid_tick);
        end
        En = 1'b1;
        chk("en_low_no_ticks", ticks, 0);
        wait_tick(100, n);
        chk("en_low_delay", 55 + n, 70);

        // Resync with En low at phase 9.
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            if (m_ntick % int'(OVS) == 9) found = 1;
            else wait_tick(100, n);
        end
        chk("phase9_reached", found, 1);
        repeat (3) cycle();
        chk("pre_resync_phase", int'(Phase), 9);
        En = 1'b0; Resync = 1'b1;
        cycle();
        Resync = 1'b0;
        chk("resync_phase0", int'(Phase), 0);
        En = 1'b1;
        wait_tick(100, n);
        chk("resync_period", n, 20);

        // Span table: load, resync, then time N ticks from the resync edge.
        for (int i = 0; i < 6; i++) begin
            Div_int  = INT_W'(vecs[i].di);
            Div_frac = FRAC_W'(vecs[i].df);
            Div_load = 1'b1;
            cycle();
            Div_load = 1'b0; Resync = 1'b1;
            cycle();
            Resync = 1'b0;
            span = -1; tcount = 0;
            for (int c = 1; c <= 400; c++) begin
                cycle();
                if (Tick) tcount++;
                if (tcount == vecs[i].nticks) begin
                    span = c;
                    break;
                end
            end
`ifdef UART_BAUD_FRAC_EN
            chk($sformatf("span[%0d]", i), span, vecs[i].span_frac);
`else
            chk($sformatf("span[%0d]", i), span, vecs[i].span_int);
`endif
        end

        // Asynchronous reset while ticking every cycle.
        Div_int = INT_W'(1); Div_frac = '0; Div_load = 1'b1;
        cycle();
        Div_load = 1'b0; Resync = 1'b1;
        cycle();
        Resync = 1'b0;
        repeat (5) cycle();
        chk("pre_rst_tick", int'(Tick), 1);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", int'({Tick, Bit_tick, Mid_tick, Div_ack, Phase}), 0);
        model_reset();
        repeat (2) cycle();
        Rst_n = 1'b1;
        wait_tick(400, n);
        chk("post_rst_first_tick", n, 325);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            En       = ($urandom_range(0, 9) != 0);
            Resync   = ($urandom_range(0, 49) == 0);
            Div_load = ($urandom_range(0, 19) == 0);
            Div_int  = INT_W'($urandom_range(0, 6));
            Div_frac = FRAC_W'($urandom());
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
